// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl_if                                       |
// | Brief    : Hazard inputs, stall/flush controls and perf counters bundle  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic             use_rs1D;
  logic             use_rs2D;
  logic [4:0]       rdE;
  logic             loadE;
  logic             validE;
  logic             redirectE;
  logic             mem_reqM;
  logic             mem_readyM;
  logic             validM;
  logic             clr_cnt;

  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushD;
  logic             bubbleE;
  logic             busy;
  logic             mem_timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: drives hazard sources, consumes controls and counters.
  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rdE, loadE, validE, redirectE,
           mem_reqM, mem_readyM, validM, clr_cnt,
    input  stallF, stallD, stallE, stallM, flushD, bubbleE, busy, mem_timeout,
           cycle_cnt, instret_cnt, stall_cnt
  );

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rdE, loadE, validE, redirectE,
           mem_reqM, mem_readyM, validM, clr_cnt,
    output stallF, stallD, stallE, stallM, flushD, bubbleE, busy, mem_timeout,
           cycle_cnt, instret_cnt, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                          |
// | Brief    : F/D/E/M stall/flush controller, perf counters, mem watchdog   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [0:0]           c_RUN      = 1'b0;
  localparam logic [0:0]           c_MEM_WAIT = 1'b1;
  localparam logic [TIMEOUT_W-1:0] c_WD_MAX   = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] c_WD_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

  logic [0:0]           r_state;
  logic [0:0]           w_stateNext;
  logic                 w_memWait;
  logic                 w_rs1Hit;
  logic                 w_rs2Hit;
  logic                 w_loadUse;
  logic [TIMEOUT_W-1:0] r_wdCnt;
  logic [TIMEOUT_W-1:0] w_wdInc;
  logic                 r_memTimeout;
  logic [CNT_W-1:0]     r_cycleCnt;
  logic [CNT_W-1:0]     r_instretCnt;
  logic [CNT_W-1:0]     r_stallCnt;

  assign w_memWait = hz.mem_reqM & ~hz.mem_readyM;
  assign w_rs1Hit  = hz.use_rs1D & (hz.rs1D == hz.rdE);
  assign w_rs2Hit  = hz.use_rs2D & (hz.rs2D == hz.rdE);
  assign w_loadUse = hz.validE & hz.loadE & (hz.rdE != 5'd0) & (w_rs1Hit | w_rs2Hit);

  // A memory wait freezes the whole pipe, so redirect/load-use stay pending in E.
  always_comb begin
    hz.stallF  = 1'b0;
    hz.stallD  = 1'b0;
    hz.stallE  = 1'b0;
    hz.stallM  = 1'b0;
    hz.flushD  = 1'b0;
    hz.bubbleE = 1'b0;
    if (w_memWait) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
    end else if (hz.redirectE) begin
      hz.flushD  = 1'b1;
      hz.bubbleE = 1'b1;
    end else if (w_loadUse) begin
      hz.stallF  = 1'b1;
      hz.stallD  = 1'b1;
      hz.bubbleE = 1'b1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_RUN:      if (w_memWait)     w_stateNext = c_MEM_WAIT;
      c_MEM_WAIT: if (hz.mem_readyM) w_stateNext = c_RUN;
      default:                       w_stateNext = c_RUN;
    endcase
  end

  assign w_wdInc = (r_wdCnt == c_WD_MAX) ? r_wdCnt : r_wdCnt + TIMEOUT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_RUN;
      r_wdCnt      <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == c_RUN) begin
        if (w_memWait) begin
          r_wdCnt <= '0;
        end
      end else begin
        r_wdCnt <= w_wdInc;
        // Sticky error only; the FSM keeps waiting for the memory.
        if (w_wdInc >= c_WD_LIMIT) begin
          r_memTimeout <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || hz.clr_cnt) begin
      r_cycleCnt   <= '0;
      r_instretCnt <= '0;
      r_stallCnt   <= '0;
    end else begin
      r_cycleCnt <= r_cycleCnt + CNT_W'(1);
      if (hz.validM && !w_memWait) begin
        r_instretCnt <= r_instretCnt + CNT_W'(1);
      end
      if (hz.stallF) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
    end
  end

  assign hz.busy        = (r_state == c_MEM_WAIT);
  assign hz.mem_timeout = r_memTimeout;
  assign hz.cycle_cnt   = r_cycleCnt;
  assign hz.instret_cnt = r_instretCnt;
  assign hz.stall_cnt   = r_stallCnt;

endmodule
`default_nettype wire
